mac_layer_engine: RTL and testbench

MAC_LAYER_ENGINE -- requirements
Module: mac_layer_engine

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_lane.sv | 51 +++++
 rtl/mac_layer_engine.sv | 161 ++++++++++++++++
 tb/tb_mac_layer_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC layer engine: controller state encoding and
// saturation bounds derived from the accumulator width.
package mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_OUT,
    S_DONE
  } state_t;

  // Largest and smallest value representable in an acc_w-bit two's complement word
  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One saturating multiply-accumulate lane: acc <= sat(acc + a*w) when enabled,
// synchronous clear for the start of a new dot product.
module mac_lane
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     w,
  output logic [ACC_W-1:0] acc
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic [2*W-1:0]   a_ext;
  logic [2*W-1:0]   w_ext;
  logic [2*W-1:0]   prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;

  assign a_ext = {{W{a[W-1]}}, a};
  assign w_ext = {{W{w[W-1]}}, w};
  assign prod  = a_ext * w_ext;

  // One guard bit is enough: |prod| never exceeds a quarter of the accumulator range
  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 2 * W){prod[2*W-1]}}, prod};

  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/mac_layer_engine.sv
// Layer engine: streams K weight/input pairs from BRAM into N_MACS parallel
// saturating MAC lanes, then emits one result per lane over a valid/ready stream.
module mac_layer_engine
  import mac_pkg::*;
#(
  parameter int W       = 8,
  parameter int ACC_W   = 16,
  parameter int N_MACS  = 4,
  parameter int K_MAX   = 256,
  parameter int WADDR_W = 11,
  parameter int IADDR_W = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
  input  logic [WADDR_W-1:0]           cfg_w_base,
  input  logic [IADDR_W-1:0]           cfg_i_base,
  input  logic                         cfg_relu,
  output logic                         weight_bram_en,
  output logic [WADDR_W-1:0]           weight_bram_addr,
  input  logic [N_MACS*W-1:0]          weight_bram_dout,
  output logic                         input_bram_en,
  output logic [IADDR_W-1:0]           input_bram_addr,
  input  logic [W-1:0]                 input_bram_dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_data,
  output logic [$clog2(N_MACS)-1:0]    out_lane,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int LW = $clog2(N_MACS);
  localparam logic [LW-1:0] LAST_LANE = LW'(N_MACS - 1);

  state_t state, state_nxt;

  logic [KW-1:0]      k_cnt;
  logic [KW-1:0]      k_q;
  logic [WADDR_W-1:0] w_base_q;
  logic [IADDR_W-1:0] i_base_q;
  logic               relu_q;
  logic [LW-1:0]      lane_cnt;
  logic               rd_valid;
  logic               accept;
  logic               cfg_bad;
  logic               cfg_ok;
  logic [ACC_W-1:0]   acc [N_MACS];
  logic [ACC_W-1:0]   out_sel;

  assign cfg_ok = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    cfg_bad        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    out_valid      = 1'b0;
    weight_bram_en = 1'b0;
    input_bram_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept    = 1'b1;
            state_nxt = S_RUN;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      S_RUN: begin
        busy           = 1'b1;
        weight_bram_en = 1'b1;
        input_bram_en  = 1'b1;
        if (k_cnt == k_q - 1'b1) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy      = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && lane_cnt == LAST_LANE) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // rd_valid marks the cycle in which BRAM data for the previous request is on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cnt    <= '0;
      k_q      <= '0;
      w_base_q <= '0;
      i_base_q <= '0;
      relu_q   <= 1'b0;
      lane_cnt <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err      <= cfg_bad;
      rd_valid <= weight_bram_en;
      if (accept) begin
        k_q      <= cfg_k;
        w_base_q <= cfg_w_base;
        i_base_q <= cfg_i_base;
        relu_q   <= cfg_relu;
        k_cnt    <= '0;
        lane_cnt <= '0;
      end else if (state == S_RUN) begin
        k_cnt <= k_cnt + 1'b1;
      end
      if (out_valid && out_ready) begin
        lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
      end
    end
  end

  assign weight_bram_addr = weight_bram_en ? w_base_q + WADDR_W'(k_cnt) : '0;
  assign input_bram_addr  = input_bram_en  ? i_base_q + IADDR_W'(k_cnt) : '0;

  for (genvar l = 0; l < N_MACS; l++) begin : g_lane
    mac_lane #(
      .W    (W),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(accept),
      .en (rd_valid),
      .a  (input_bram_dout),
      .w  (weight_bram_dout[l*W +: W]),
      .acc(acc[l])
    );
  end

  assign out_sel  = acc[lane_cnt];
  assign out_data = !out_valid ? '0 : ((relu_q && out_sel[ACC_W-1]) ? '0 : out_sel);
  assign out_lane = out_valid ? lane_cnt : '0;
  assign out_last = out_valid && (lane_cnt == LAST_LANE);

endmodule

// File: tb/tb_mac_layer_engine.sv
// Self-checking bench for mac_layer_engine: BRAM models, an arithmetic reference
// model of the dot products, directed corner cases and randomized layer runs.
module tb_mac_layer_engine;

  localparam int W       = 8;
  localparam int ACC_W   = 16;
  localparam int N_MACS  = 4;
  localparam int K_MAX   = 256;
  localparam int WADDR_W = 11;
  localparam int IADDR_W = 9;
  localparam int KW      = $clog2(K_MAX + 1);
  localparam int LW      = $clog2(N_MACS);
  localparam int WDEPTH  = 1 << WADDR_W;
  localparam int IDEPTH  = 1 << IADDR_W;
  localparam longint RMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint RMIN = -(longint'(1) <<< (ACC_W - 1));

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [KW-1:0]         cfg_k;
  logic [WADDR_W-1:0]    cfg_w_base;
  logic [IADDR_W-1:0]    cfg_i_base;
  logic                  cfg_relu;
  logic                  weight_bram_en;
  logic [WADDR_W-1:0]    weight_bram_addr;
  logic [N_MACS*W-1:0]   weight_bram_dout;
  logic                  input_bram_en;
  logic [IADDR_W-1:0]    input_bram_addr;
  logic [W-1:0]          input_bram_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic [LW-1:0]         out_lane;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  logic [N_MACS*W-1:0]   weight_mem [WDEPTH];
  logic [W-1:0]          input_mem  [IDEPTH];
  longint                exp_out    [N_MACS];
  int                    w_addr_q[$];
  int                    i_addr_q[$];
  int                    done_cnt;
  int                    checks = 0;
  int                    errors = 0;

  always #5 clk = ~clk;

  mac_layer_engine #(
    .W(W), .ACC_W(ACC_W), .N_MACS(N_MACS), .K_MAX(K_MAX),
    .WADDR_W(WADDR_W), .IADDR_W(IADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k),
    .cfg_w_base(cfg_w_base), .cfg_i_base(cfg_i_base), .cfg_relu(cfg_relu),
    .weight_bram_en(weight_bram_en), .weight_bram_addr(weight_bram_addr),
    .weight_bram_dout(weight_bram_dout), .input_bram_en(input_bram_en),
    .input_bram_addr(input_bram_addr), .input_bram_dout(input_bram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  // Single-cycle-latency BRAM models
  always @(posedge clk) begin
    if (weight_bram_en) weight_bram_dout <= weight_mem[weight_bram_addr];
    if (input_bram_en)  input_bram_dout  <= input_mem[input_bram_addr];
  end

  always @(negedge clk) begin
    if (weight_bram_en) w_addr_q.push_back(int'(weight_bram_addr));
    if (input_bram_en)  i_addr_q.push_back(int'(input_bram_addr));
    if (done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " err"}, err, 0);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " weight_en"}, weight_bram_en, 0);
    checkOutput({tag, " input_en"}, input_bram_en, 0);
    checkOutput({tag, " weight_addr"}, weight_bram_addr, 0);
    checkOutput({tag, " input_addr"}, input_bram_addr, 0);
    checkOutput({tag, " out_data"}, out_data, 0);
    checkOutput({tag, " out_lane"}, out_lane, 0);
    checkOutput({tag, " out_last"}, out_last, 0);
  endtask

  // Reference: plain saturating dot product per lane over wrapped addresses
  task automatic computeExpected(input int k, input int w_base, input int i_base, input bit relu);
    logic [N_MACS*W-1:0] word;
    logic signed [W-1:0] a_s;
    logic signed [W-1:0] w_s;
    longint              acc;
    for (int l = 0; l < N_MACS; l++) begin
      acc = 0;
      for (int j = 0; j < k; j++) begin
        a_s  = input_mem[(i_base + j) % IDEPTH];
        word = weight_mem[(w_base + j) % WDEPTH];
        w_s  = word[l*W +: W];
        acc  = acc + longint'(a_s) * longint'(w_s);
        if (acc > RMAX) acc = RMAX;
        if (acc < RMIN) acc = RMIN;
      end
      exp_out[l] = (relu && acc < 0) ? 0 : acc;
    end
  endtask

  // Runs one layer starting at posedge+1; optionally stalls one lane and pokes start mid-run
  task automatic applyStimulus(input int k, input int w_base, input int i_base, input bit relu,
                               input int stall_lane, input int stall_cycles, input bit poke);
    int cyc;
    int lane;
    int stall;
    int stall_total;
    computeExpected(k, w_base, i_base, relu);
    stall_total = (stall_lane < N_MACS) ? stall_cycles : 0;
    w_addr_q.delete();
    i_addr_q.delete();
    done_cnt   = 0;
    start      = 1'b1;
    cfg_k      = KW'(k);
    cfg_w_base = WADDR_W'(w_base);
    cfg_i_base = IADDR_W'(i_base);
    cfg_relu   = relu;
    @(posedge clk); #1;
    start      = 1'b0;
    cfg_k      = KW'($urandom);
    cfg_w_base = WADDR_W'($urandom);
    cfg_i_base = IADDR_W'($urandom);
    cfg_relu   = 1'($urandom);
    checkOutput("busy after start", busy, 1);
    cyc = 0;
    while (!out_valid && cyc <= k + 4) begin
      start = poke && (cyc == 0);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("first out_valid latency", cyc, k + 1);
    lane  = 0;
    stall = stall_cycles;
    cyc   = 0;
    while (lane < N_MACS && cyc < 100) begin
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_lane", out_lane, lane);
      checkOutput($sformatf("out_data lane%0d", lane), longint'($signed(out_data)), exp_out[lane]);
      checkOutput("out_last", out_last, lane == N_MACS - 1);
      if (lane == stall_lane && stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
        lane++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    checkOutput("lanes drained", lane, N_MACS);
    checkOutput("valid-to-done cycles", cyc, N_MACS + stall_total);
    checkOutput("done pulse", done, 1);
    checkOutput("busy in DONE", busy, 0);
    @(posedge clk); #1;
    checkOutput("done cleared", done, 0);
    checkOutput("idle after run", busy, 0);
    checkOutput("done count", done_cnt, 1);
    checkOutput("weight req count", w_addr_q.size(), k);
    checkOutput("input req count", i_addr_q.size(), k);
    for (int i = 0; i < k && i < w_addr_q.size(); i++)
      checkOutput("weight addr", w_addr_q[i], (w_base + i) % WDEPTH);
    for (int i = 0; i < k && i < i_addr_q.size(); i++)
      checkOutput("input addr", i_addr_q[i], (i_base + i) % IDEPTH);
  endtask

  task automatic badConfig(input int k);
    start = 1'b1;
    cfg_k = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput($sformatf("err pulse k=%0d", k), err, 1);
    checkOutput("busy on bad cfg", busy, 0);
    @(posedge clk); #1;
    checkOutput("err one cycle", err, 0);
    checkOutput("still idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_w_base = '0; cfg_i_base = '0;
    cfg_relu = 1'b0; out_ready = 1'b1; done_cnt = 0;
    for (int i = 0; i < WDEPTH; i++) weight_mem[i] = (N_MACS*W)'($urandom);
    for (int i = 0; i < IDEPTH; i++) input_mem[i]  = W'($urandom);
    repeat (2) @(posedge clk); #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    input_mem[0]  = 8'd3;
    weight_mem[0] = {8'd4, 8'hFF, 8'd2, 8'd1};
    applyStimulus(1, 0, 0, 1'b0, N_MACS, 0, 1'b0);
    applyStimulus(1, 0, 0, 1'b1, N_MACS, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      input_mem[100 + i]  = 8'd127;
      input_mem[200 + i]  = 8'h80;
      weight_mem[100 + i] = {N_MACS{8'd127}};
    end
    applyStimulus(4, 100, 100, 1'b0, N_MACS, 0, 1'b0);
    applyStimulus(4, 100, 200, 1'b0, N_MACS, 0, 1'b0);
    applyStimulus(4, 100, 200, 1'b1, N_MACS, 0, 1'b0);

    applyStimulus(2, 300, 50, 1'b0, 2, 5, 1'b0);
    applyStimulus(4, 2046, 510, 1'b0, N_MACS, 0, 1'b0);

    badConfig(0);
    badConfig(300);
    applyStimulus(3, 17, 33, 1'b0, N_MACS, 0, 1'b1);

    start = 1'b1; cfg_k = KW'(8); cfg_w_base = '0; cfg_i_base = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy before abort", busy, 1);
    done_cnt = 0;
    rst = 1'b1;
    #1;
    checkResetOutputs("mid-run reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (N_MACS + 12) @(posedge clk);
    #1;
    checkOutput("no done after abort", done_cnt, 0);
    checkOutput("idle after abort", busy, 0);
    applyStimulus(1, 5, 7, 1'b0, N_MACS, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      applyStimulus(int'($urandom_range(1, 12)), int'($urandom_range(0, WDEPTH - 1)),
                    int'($urandom_range(0, IDEPTH - 1)), 1'($urandom),
                    int'($urandom_range(0, N_MACS)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
